mips_mem_unit: RTL and testbench
================================

Name: mips_mem_unit

Overview:
- Parametrised memory-access unit for the multicycle MIPS core. It replaces the fixed single-cycle memData/MemWrite/MemMode/memAddr path with a request/response handshake toward a variable-latency memory.
- Handles word, halfword and byte loads and stores, using byte enables and sign or zero extension.
- Detects misaligned accesses and memory timeouts.
- Asserts a stall to the controller while an access is outstanding.

Parameters:
- ADDR_WIDTH, 16: byte-address width on both the core side and the memory side.
- TIMEOUT, 16: maximum number of cycles mem_req stays high without mem_ack before the access aborts with an error. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core requests an access; sampled only while req_ready=1.
- req_ready  out  1  unit is idle and will accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_mode  in  2  00 word, 01 halfword, 10 byte, 11 reserved.
- req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: misaligned access, reserved mode, or timeout.
- stall  out  1  high while an access is outstanding at the memory.
- mem_req  out  1  memory request, held until acknowledged or timed out.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits = 0.
- mem_be  out  4  byte enables; bit i selects mem_wdata[8i+7:8i].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, sampled only in ACCESS.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (asynchronous, immediate):
  - state = IDLE; timeout counter = 0.
  - All registered outputs = 0.
  - req_ready = 1 (it decodes state == IDLE).
  - stall = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture all req_* fields into internal registers. Request inputs are ignored in every other state.
  - Misaligned (word with addr[1:0] != 0, halfword with addr[0] = 1) or mode 11: go to RESP with rsp_err = 1. No mem_req is issued.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req = 1 and stall = 1.
  - mem_addr, mem_we, mem_be and mem_wdata stay stable for the whole state.
  - On the edge that samples mem_ack = 1: capture mem_rdata and go to RESP with rsp_err = 0.
  - If mem_ack = 0 and TIMEOUT != 0, the counter increments. When the counter equals TIMEOUT-1 with no ack, go to RESP with rsp_err = 1. mem_req is therefore high for exactly TIMEOUT cycles.
  - Counter width is clog2(TIMEOUT+1); it clears on entry to ACCESS.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_valid is 0 in every other state.
- Latency: request accepted at edge E0 → mem_req high after E0 → ack sampled at E1 → rsp_valid high after E1 → IDLE after E2. Zero-wait access: 3 cycles from acceptance back to req_ready. Each memory wait cycle adds 1.
- Byte lanes are little-endian; lane = addr[1:0].
  - Word: mem_be = 1111, mem_wdata = wdata.
  - Halfword: mem_be = 0011 << (2*addr[1]), mem_wdata = {2{wdata[15:0]}}.
  - Byte: mem_be = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
- Load extraction:
  - Halfword = mem_rdata[16*addr[1] +: 16].
  - Byte = mem_rdata[8*addr[1:0] +: 8].
  - Sign- or zero-extend to 32 bits per req_unsigned. Word is passed through unchanged.
- Stores: rsp_rdata = 0. mem_rdata is ignored.
- Errors: rsp_rdata = 0.
- mem_ack outside ACCESS, including a late ack after a timeout, is ignored and has no effect.
- Outputs while not in ACCESS:
  - mem_req = 0.
  - mem_be = 0000.
  - mem_we = 0.
  - mem_addr and mem_wdata hold their last values.
- Reset during ACCESS aborts the access at once: mem_req drops asynchronously and no rsp_valid is produced for the aborted request.

Test Plan:
- Word load, addr 0x0010; memory acks in the first mem_req cycle with 0xDEADBEEF → mem_addr 0x0010, mem_be 1111; rsp_valid 2 cycles after acceptance; rsp_rdata 0xDEADBEEF, rsp_err 0; req_ready back on cycle 3.
- Byte load, addr 0x0013, mem_rdata 0x80FF1234 → signed: rsp_rdata 0xFFFFFF80; unsigned: 0x00000080. Halfword load, addr 0x0012, signed → 0xFFFF80FF.
- Halfword store, addr 0x0022, wdata 0x1234ABCD, 3 wait cycles → mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1; mem_req and stall high for 4 cycles with stable signals; one rsp_valid, rsp_rdata 0.
- Misaligned word load at 0x0006, then mode 11 at 0x0000 → no mem_req; rsp_valid with rsp_err = 1 one cycle after acceptance, each time.
- TIMEOUT = 16, memory never acks → mem_req high exactly 16 cycles, then rsp_valid with rsp_err = 1; an ack injected 2 cycles later is ignored and the next request proceeds normally.
- Reset asserted mid-ACCESS, between clock edges → mem_req and stall drop immediately; req_ready = 1; no rsp_valid after release; a fresh request completes correctly.

Source files
------------

// File: rtl/mips_mem_unit_if.sv
// Core-side request/response and memory-side bus of the MIPS memory-access unit.
// The unit connects through the slave modport; the core/memory side uses master.
interface mips_mem_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_mode;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  stall;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ack;

    modport slave (
        input  req_valid, req_write, req_mode, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output req_valid, req_write, req_mode, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_mem_unit.sv
// Load/store unit: one request at a time to a variable-latency memory, with byte lanes,
// extension, misalignment and timeout errors. Zero-wait access returns to idle in 3 cycles.
module mips_mem_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            reset,
    mips_mem_unit_if.slave  bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic                  write_q;
    logic [1:0]            mode_q;
    logic                  uns_q;
    logic [1:0]            lane_q;
    logic [3:0]            be_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  bad_req;
    logic                  timed_out;
    logic [3:0]            be_calc;
    logic [31:0]           wdata_calc;
    logic [31:0]           load_data;
    logic [15:0]           half_sel;
    logic [7:0]            byte_sel;

    assign bad_req = (bus.req_mode == 2'b11)
                  || (bus.req_mode == 2'b00 && bus.req_addr[1:0] != 2'b00)
                  || (bus.req_mode == 2'b01 && bus.req_addr[0]);

    assign timed_out = (TIMEOUT != 0) && !bus.mem_ack && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = bad_req ? RESP : ACCESS;
            ACCESS:  if (bus.mem_ack || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = bus.req_wdata;
        case (bus.req_mode)
            2'b01: begin
                be_calc    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                be_calc    = 4'b0001 << bus.req_addr[1:0];
                wdata_calc = {4{bus.req_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Lane extraction uses the captured address, not the live request port.
    assign half_sel = bus.mem_rdata[16*lane_q[1] +: 16];
    assign byte_sel = bus.mem_rdata[8*lane_q +: 8];

    always_comb begin
        load_data = bus.mem_rdata;
        case (mode_q)
            2'b01:   load_data = {{16{half_sel[15] & ~uns_q}}, half_sel};
            2'b10:   load_data = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            write_q     <= 1'b0;
            mode_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            be_q        <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    write_q     <= bus.req_write;
                    mode_q      <= bus.req_mode;
                    uns_q       <= bus.req_unsigned;
                    lane_q      <= bus.req_addr[1:0];
                    cnt         <= '0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= bad_req;
                    if (!bad_req) begin
                        be_q        <= be_calc;
                        mem_addr_q  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= wdata_calc;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= write_q ? 32'h0 : load_data;
                    end else if (timed_out) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decoded from state so reset drops the memory request asynchronously.
    assign bus.req_ready = (state == IDLE);
    assign bus.stall     = (state == ACCESS);
    assign bus.mem_req   = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && write_q;
    assign bus.mem_be    = (state == ACCESS) ? be_q : 4'b0000;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mips_mem_unit.sv
// Directed and random load/store sequences against an arithmetic reference of lanes,
// extension, alignment and timeout.
module tb_mips_mem_unit;
    localparam int AW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mips_mem_unit_if #(.ADDR_WIDTH(AW)) bus ();

    mips_mem_unit #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [1:0] mode, input logic [15:0] addr);
        int a = int'(addr);
        if (mode == 2'd3) return 1'b1;
        if (mode == 2'd0) return (a % 4) != 0;
        if (mode == 2'd1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] mode, input logic [15:0] addr);
        int lane = int'(addr) % 4;
        if (mode == 2'd0) return 4'd15;
        if (mode == 2'd1) return 4'(3 << (2 * (lane / 2)));
        return 4'(1 << lane);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] mode, input logic [31:0] w);
        if (mode == 2'd0) return w;
        if (mode == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return (w & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] mode, input bit uns,
                                             input logic [15:0] addr, input logic [31:0] d);
        int lane = int'(addr) % 4;
        logic [31:0] v;
        if (mode == 2'd0) return d;
        if (mode == 2'd1) begin
            v = (d >> (16 * (lane / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = (d >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end
        return v;
    endfunction

    // waits < 0 means the memory never acknowledges.
    task automatic access(input bit wr, input logic [1:0] mode, input bit uns,
                          input logic [15:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
        bit acked;
        int n_req;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_mode     = mode;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wd;
        bus.req_mode  = ~mode;
        if (ref_bad(mode, addr)) begin
            chk("err_mem_req", 32'(bus.mem_req), 32'd0);
            chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("err_rsp_err", 32'(bus.rsp_err), 32'd1);
            chk("err_rsp_rdata", bus.rsp_rdata, 32'd0);
            @(negedge clk);
            chk("err_rsp_done", 32'(bus.rsp_valid), 32'd0);
            chk("err_ready_back", 32'(bus.req_ready), 32'd1);
            return;
        end
        acked = (waits >= 0) && (waits < TO);
        n_req = acked ? waits + 1 : TO;
        for (int i = 0; i < n_req; i++) begin
            if (i > 0) @(negedge clk);
            chk("mem_req", 32'(bus.mem_req), 32'd1);
            chk("stall", 32'(bus.stall), 32'd1);
            chk("mem_we", 32'(bus.mem_we), 32'(wr));
            chk("mem_addr", 32'(bus.mem_addr), 32'(addr & 16'hFFFC));
            chk("mem_be", 32'(bus.mem_be), 32'(ref_be(mode, addr)));
            if (wr) chk("mem_wdata", bus.mem_wdata, ref_wdata(mode, wd));
            chk("no_rsp_in_access", 32'(bus.rsp_valid), 32'd0);
            bus.mem_ack   = acked && (i == waits);
            bus.mem_rdata = (acked && i == waits) ? rd : $urandom;
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("rsp_mem_req_low", 32'(bus.mem_req), 32'd0);
        chk("rsp_stall_low", 32'(bus.stall), 32'd0);
        chk("rsp_be_zero", 32'(bus.mem_be), 32'd0);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_err", 32'(bus.rsp_err), 32'(!acked));
        chk("rsp_rdata", bus.rsp_rdata, (acked && !wr) ? ref_load(mode, uns, addr, rd) : 32'd0);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        chk("ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_mode     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_rdata    = '0;
        bus.mem_ack      = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        #11 reset = 1'b0;

        access(1'b0, 2'd0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);
        access(1'b0, 2'd2, 1'b0, 16'h0013, 32'h0, 32'h80FF1234, 0);
        access(1'b0, 2'd2, 1'b1, 16'h0013, 32'h0, 32'h80FF1234, 1);
        access(1'b0, 2'd1, 1'b0, 16'h0012, 32'h0, 32'h80FF1234, 0);
        access(1'b1, 2'd1, 1'b0, 16'h0022, 32'h1234ABCD, 32'hFFFFFFFF, 3);
        access(1'b0, 2'd0, 1'b0, 16'h0006, 32'h0, 32'h0, 0);
        access(1'b0, 2'd3, 1'b0, 16'h0000, 32'h0, 32'h0, 0);

        // Timeout, then a stray late ack while idle.
        access(1'b0, 2'd0, 1'b0, 16'h0040, 32'h0, 32'h0, -1);
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late_ack_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("late_ack_no_req", 32'(bus.mem_req), 32'd0);
        chk("late_ack_ready", 32'(bus.req_ready), 32'd1);
        access(1'b0, 2'd1, 1'b1, 16'h0046, 32'h0, 32'hCAFE8001, 2);

        // Reset in the middle of an access, between clock edges.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_mode  = 2'd0;
        bus.req_addr  = 16'h0030;
        bus.req_wdata = 32'h01020304;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        access(1'b0, 2'd2, 1'b0, 16'h0031, 32'h0, 32'h00007F00, 1);

        for (int n = 0; n < 40; n++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   16'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
